// File: rtl/mux16_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux16_rr_arbiter_pkg
//  Purpose  : Shared sizes and FSM encoding for the 16-way round-robin
//             selector arbiter and its find-first helper.
//  Contents : ARB_N, ARB_SEL_W, state encoding constants, state enum.
//  Revision : 1.0  initial release
// ============================================================================
package mux16_rr_arbiter_pkg;

    localparam int ARB_N     = 16;
    localparam int ARB_SEL_W = 4;

    localparam logic c_IDLE  = 1'b0;
    localparam logic c_GRANT = 1'b1;

    typedef enum logic {
        S_IDLE  = c_IDLE,
        S_GRANT = c_GRANT
    } arb_state_e;

endpackage : mux16_rr_arbiter_pkg
`default_nettype wire

// File: rtl/rr_find_first16.sv
`default_nettype none
// ============================================================================
//  Module   : rr_find_first16
//  Purpose  : Combinational rotating-priority search. Returns the first set
//             request bit scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1.
//  Ports    : req_i[15:0] request vector
//             ptr_i[3:0]  highest-priority index
//             any_o       at least one request is set
//             idx_o[3:0]  index of the winning request (valid when any_o)
//  Revision : 1.0  initial release
// ============================================================================
module rr_find_first16
    import mux16_rr_arbiter_pkg::*;
(
    input  logic [ARB_N-1:0]     req_i,
    input  logic [ARB_SEL_W-1:0] ptr_i,
    output logic                 any_o,
    output logic [ARB_SEL_W-1:0] idx_o
);

    logic [ARB_N-1:0]     w_rot;
    logic [ARB_SEL_W-1:0] w_off;

    // Rotate right by ptr so that bit 0 of w_rot is requester ptr. The 4-bit
    // index addition wraps naturally mod 16.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < ARB_N; i++) begin
            w_rot[i] = req_i[ARB_SEL_W'(i) + ptr_i];
        end
    end

    // Lowest set bit of the rotated vector; scanning downward lets the
    // lowest index overwrite any higher one.
    always_comb begin
        w_off = '0;
        for (int i = ARB_N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = ARB_SEL_W'(i);
            end
        end
    end

    assign any_o = |req_i;
    assign idx_o = w_off + ptr_i;

endmodule : rr_find_first16
`default_nettype wire

// File: rtl/mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux16_rr_arbiter
//  Purpose  : Round-robin arbiter owning the select lines of a shared 16:1
//             single-bit selector. Grants are held until the owner releases
//             (done or dropping its request) or MAX_HOLD cycles elapse. A
//             one-cycle idle bubble separates consecutive grants so the select
//             never moves while grant_valid is high.
//  Ports    : clock, reset        clock / synchronous active-high reset
//             req[15:0]           request vector
//             done                current owner releases its grant
//             grant_valid         a grant is active, select is stable
//             grant_sel[3:0]      granted index, drives select[3:0]
//             grant_onehot[15:0]  one-hot of grant_sel, zero when idle
//             forced_release      one-cycle pulse: grant ended by MAX_HOLD
//  Revision : 1.0  initial release
// ============================================================================
module mux16_rr_arbiter
    import mux16_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 32,
    parameter int HOLD_W   = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ARB_N-1:0]     req,
    input  logic                 done,
    output logic                 grant_valid,
    output logic [ARB_SEL_W-1:0] grant_sel,
    output logic [ARB_N-1:0]     grant_onehot,
    output logic                 forced_release
);

    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [ARB_N-1:0]  c_ONE       = {{(ARB_N-1){1'b0}}, 1'b1};

    arb_state_e           state_q;
    logic [ARB_SEL_W-1:0] ptr_q;
    logic [HOLD_W-1:0]    cnt_q;
    logic                 grant_valid_q;
    logic [ARB_SEL_W-1:0] grant_sel_q;
    logic [ARB_N-1:0]     grant_onehot_q;
    logic                 forced_release_q;

    logic                 w_any;
    logic [ARB_SEL_W-1:0] w_idx;
    logic                 w_owner_req;
    logic                 w_hold_hit;
    logic                 w_release;
    logic                 w_forced;

    rr_find_first16 u_find (
        .req_i (req),
        .ptr_i (ptr_q),
        .any_o (w_any),
        .idx_o (w_idx)
    );

    assign w_owner_req = req[grant_sel_q];
    assign w_hold_hit  = (MAX_HOLD != 0) && (cnt_q == c_HOLD_LAST);
    assign w_release   = done || !w_owner_req || w_hold_hit;
    // Only flag a forced release when the owner had not already let go.
    assign w_forced    = w_hold_hit && !done && w_owner_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= S_IDLE;
            ptr_q            <= '0;
            cnt_q            <= '0;
            grant_valid_q    <= 1'b0;
            grant_sel_q      <= '0;
            grant_onehot_q   <= '0;
            forced_release_q <= 1'b0;
        end else begin
            forced_release_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_any) begin
                        state_q        <= S_GRANT;
                        grant_valid_q  <= 1'b1;
                        grant_sel_q    <= w_idx;
                        grant_onehot_q <= c_ONE << w_idx;
                        cnt_q          <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        state_q          <= S_IDLE;
                        grant_valid_q    <= 1'b0;
                        grant_onehot_q   <= '0;
                        // Owner moves to lowest priority; 4-bit add wraps 15->0.
                        ptr_q            <= grant_sel_q + ARB_SEL_W'(1);
                        forced_release_q <= w_forced;
                    end else begin
                        cnt_q <= cnt_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_valid    = grant_valid_q;
    assign grant_sel      = grant_sel_q;
    assign grant_onehot   = grant_onehot_q;
    assign forced_release = forced_release_q;

endmodule : mux16_rr_arbiter
`default_nettype wire

// File: tb/tb_mux16_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux16_rr_arbiter
//  Purpose  : Directed self-checking bench for mux16_rr_arbiter. Each step
//             drives req/done/reset, queues the outputs expected after the
//             next rising edge, then pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux16_rr_arbiter;

    logic        clock;
    logic        reset;
    logic [15:0] req;
    logic        done;
    logic        grant_valid;
    logic [3:0]  grant_sel;
    logic [15:0] grant_onehot;
    logic        forced_release;

    typedef struct packed {
        logic        v;
        logic [3:0]  s;
        logic [15:0] oh;
        logic        f;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [3:0] last_sel = 4'd0;

    mux16_rr_arbiter #(.MAX_HOLD(32), .HOLD_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .done           (done),
        .grant_valid    (grant_valid),
        .grant_sel      (grant_sel),
        .grant_onehot   (grant_onehot),
        .forced_release (forced_release)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input string tag, input logic rst, input logic [15:0] r,
                        input logic d, input logic ev, input logic [3:0] es,
                        input logic ef);
        exp_t e;
        exp_t got;
        reset = rst;
        req   = r;
        done  = d;
        e.v  = ev;
        e.s  = es;
        e.oh = ev ? (16'h0001 << es) : 16'h0000;
        e.f  = ef;
        sb.push_back(e);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        checks++;
        assert (grant_valid === got.v) else begin
            errors++;
            $error("FAIL %s valid observed=%0b expected=%0b", tag, grant_valid, got.v);
        end
        checks++;
        assert (grant_sel === got.s) else begin
            errors++;
            $error("FAIL %s sel observed=%0d expected=%0d", tag, grant_sel, got.s);
        end
        checks++;
        assert (grant_onehot === got.oh) else begin
            errors++;
            $error("FAIL %s onehot observed=%h expected=%h", tag, grant_onehot, got.oh);
        end
        checks++;
        assert (forced_release === got.f) else begin
            errors++;
            $error("FAIL %s forced observed=%0b expected=%0b", tag, forced_release, got.f);
        end
        checks++;
        assert ($onehot0(grant_onehot)) else begin
            errors++;
            $error("FAIL %s onehot0 observed=%h expected=at most one bit", tag, grant_onehot);
        end
    endtask

    // Expect an idle cycle; grant_sel keeps its last granted value.
    task automatic idle(input string tag, input logic [15:0] r, input logic d,
                        input logic ef);
        step(tag, 1'b0, r, d, 1'b0, last_sel, ef);
    endtask

    task automatic grant(input string tag, input logic [15:0] r, input logic d,
                         input logic [3:0] s);
        step(tag, 1'b0, r, d, 1'b1, s, 1'b0);
        last_sel = s;
    endtask

    initial begin
        reset = 1'b1;
        req   = 16'h0000;
        done  = 1'b0;

        // Reset with every requester active.
        for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, 16'hFFFF, 1'b0, 1'b0, 4'd0, 1'b0);
        grant("first_grant", 16'hFFFF, 1'b0, 4'd0);

        // Full rotation with done pulses: 0,1,...,15,0 with one bubble each.
        for (int k = 0; k < 16; k++) begin
            idle("rr_bubble", 16'hFFFF, 1'b1, 1'b0);
            grant("rr_grant", 16'hFFFF, 1'b0, 4'((k + 1) % 16));
        end

        // Build ptr=5 by granting 4, then check wrap-around scan.
        idle("to4_rel", 16'h0010, 1'b1, 1'b0);
        grant("grant4", 16'h0010, 1'b0, 4'd4);
        idle("rel4", 16'h0010, 1'b1, 1'b0);
        grant("wrap_to0", 16'h0011, 1'b0, 4'd0);
        idle("rel0", 16'h0011, 1'b1, 1'b0);
        grant("then4", 16'h0011, 1'b0, 4'd4);
        idle("rel4b", 16'h0000, 1'b1, 1'b0);
        idle("idle_done_ignored", 16'h0000, 1'b1, 1'b0);

        // Hold limit: requester 7 never releases; 32 valid cycles total.
        grant("hold_start", 16'h0080, 1'b0, 4'd7);
        for (int i = 0; i < 31; i++) grant("hold_keep", 16'h0080, 1'b0, 4'd7);
        idle("hold_forced", 16'h0080, 1'b0, 1'b1);
        grant("hold_regrant", 16'h0080, 1'b0, 4'd7);
        idle("hold_rel", 16'h0000, 1'b1, 1'b0);

        // Owner 3 drops its request while 9 waits (ptr=8 here).
        grant("own3", 16'h0008, 1'b0, 4'd3);
        grant("own3_keep", 16'h0208, 1'b0, 4'd3);
        idle("own3_drop", 16'h0200, 1'b0, 1'b0);
        grant("then9", 16'h0200, 1'b0, 4'd9);
        idle("rel9", 16'h0000, 1'b1, 1'b0);

        // Reset during a grant to 12; pointer must restart at 0.
        grant("own12", 16'h1000, 1'b0, 4'd12);
        step("reset_mid", 1'b1, 16'h1000, 1'b0, 1'b0, 4'd0, 1'b0);
        last_sel = 4'd0;
        grant("post_reset", 16'h1001, 1'b0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux16_rr_arbiter
`default_nettype wire
